// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction per handshake, extracts and
// extends load data, drives the register-file write port and forwarding bus,
// counts retired instructions and latches the halt condition.
module wb_stage #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    input  logic             MemtoReg,
    input  logic             RegWr,
    input  logic [4:0]       Rd,
    input  logic [31:0]      ALUout,
    input  logic [2:0]       MemOp,
    input  logic [31:0]      Do,
    input  logic             done,
    input  logic [31:0]      PC,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic             retire_valid,
    output logic [31:0]      retire_pc,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    logic             r_valid;
    logic             r_memtoreg;
    logic             r_regwr;
    logic [4:0]       r_rd;
    logic [31:0]      r_aluout;
    logic [1:0]       r_addr_lo;
    logic [2:0]       r_memop;
    logic [31:0]      r_do;
    logic             r_done;
    logic [31:0]      r_pc;
    logic             r_halted;
    logic [CNT_W-1:0] r_instret;

    logic             w_recv;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_wdata;
    logic             w_we;

    // Acceptance: a retiring done-entry blocks intake in its own cycle so nothing
    // slips in behind the halting instruction.
    always_comb begin
        in_ready = rst & ~r_halted & ~hold & ~(r_valid & r_done);
        w_recv   = in_valid & in_ready;
    end

    // Capture the incoming instruction; each entry lives for exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwr    <= 1'b0;
            r_rd       <= 5'd0;
            r_aluout   <= 32'd0;
            r_addr_lo  <= 2'd0;
            r_memop    <= 3'd0;
            r_do       <= 32'd0;
            r_done     <= 1'b0;
            r_pc       <= 32'd0;
        end else begin
            r_valid <= w_recv;
            if (w_recv) begin
                r_memtoreg <= MemtoReg;
                r_regwr    <= RegWr;
                r_rd       <= Rd;
                r_aluout   <= ALUout;
                r_addr_lo  <= ALUout[1:0];
                r_memop    <= MemOp;
                r_do       <= Do;
                r_done     <= done;
                r_pc       <= PC;
            end
        end
    end

    // Retire bookkeeping: count every presented entry, halt after a done-entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else begin
            if (r_valid) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (r_valid && r_done) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = r_do[7:0];
            2'd1:    w_byte = r_do[15:8];
            2'd2:    w_byte = r_do[23:16];
            default: w_byte = r_do[31:24];
        endcase
        // addr_lo[0] is ignored for halfword accesses.
        w_half = r_addr_lo[1] ? r_do[31:16] : r_do[15:0];
        case (r_memop)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = r_do;
        endcase
    end

    // Writeback port, forwarding bus and retire outputs.
    always_comb begin
        w_wdata      = r_memtoreg ? w_load : r_aluout;
        w_we         = r_valid & r_regwr & (r_rd != 5'd0);
        rf_we        = w_we;
        rf_waddr     = r_rd;
        rf_wdata     = w_wdata;
        fwd_valid    = w_we;
        fwd_rd       = r_rd;
        fwd_data     = w_wdata;
        retire_valid = r_valid;
        retire_pc    = r_pc;
        halted       = r_halted;
        instret      = r_instret;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: randomized and directed stimulus, a
// behavioural model that pushes expected retirements into a queue, and a
// monitor that pops and compares whenever the stage presents an entry.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        hold;
    logic        MemtoReg;
    logic        RegWr;
    logic [4:0]  Rd;
    logic [31:0] ALUout;
    logic [2:0]  MemOp;
    logic [31:0] Do;
    logic        done;
    logic [31:0] PC;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        halted;
    logic [31:0] instret;

    wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
        .MemtoReg(MemtoReg), .RegWr(RegWr), .Rd(Rd), .ALUout(ALUout), .MemOp(MemOp),
        .Do(Do), .done(done), .PC(PC), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .halted(halted),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passes = 0;

    // Model state
    logic        halted_m = 1'b0;
    logic [31:0] instret_m = 32'd0;
    logic        present_m = 1'b0;
    logic        present_done_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference load result from the load-type rules.
    function automatic logic [31:0] load_ref(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] sb;
        logic [31:0] sh;
        int          s;
        sb = (d >> (8 * a)) & 32'hFF;
        sh = a[1] ? (d >> 16) : (d & 32'hFFFF);
        case (op)
            3'b000: begin s = int'(sb); if (sb >= 32'h80) s = s - 256; return 32'(s); end
            3'b001: begin s = int'(sh); if (sh >= 32'h8000) s = s - 65536; return 32'(s); end
            3'b100: return sb;
            3'b101: return sh;
            default: return d;
        endcase
    endfunction

    // Model: decide acceptance from the inputs seen at the edge and record the
    // retirement expected one cycle later.
    always @(posedge clk) begin
        logic rdy;
        exp_t e;
        if (rst) begin
            rdy = !halted_m && !hold && !(present_m && present_done_m);
            if (present_m) begin
                instret_m = instret_m + 1;
                if (present_done_m) halted_m = 1'b1;
                present_m = 1'b0;
            end
            if (in_valid && rdy) begin
                e.we    = RegWr && (Rd != 5'd0);
                e.rd    = Rd;
                e.wdata = MemtoReg ? load_ref(MemOp, ALUout[1:0], Do) : ALUout;
                e.pc    = PC;
                q.push_back(e);
                present_m      = 1'b1;
                present_done_m = done;
            end
        end
    end

    // Monitor: mid-cycle sampling of every output against the model.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        exp_rdy = rst && !halted_m && !hold && !(present_m && present_done_m);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("halted", 32'(halted), 32'(halted_m));
        chk("instret", instret, instret_m);
        chk("retire_valid", 32'(retire_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            e = q.pop_front();
            if (retire_valid) begin
                chk("rf_we", 32'(rf_we), 32'(e.we));
                chk("fwd_valid", 32'(fwd_valid), 32'(e.we));
                chk("rf_waddr", 32'(rf_waddr), 32'(e.rd));
                chk("fwd_rd", 32'(fwd_rd), 32'(e.rd));
                chk("rf_wdata", rf_wdata, e.wdata);
                chk("fwd_data", fwd_data, e.wdata);
                chk("retire_pc", retire_pc, e.pc);
            end
        end
    end

    task automatic issue(input logic v, input logic m2r, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [2:0] op, input logic [31:0] d,
                         input logic dn, input logic [31:0] pc);
        in_valid = v; MemtoReg = m2r; RegWr = rw; Rd = rd; ALUout = alu;
        MemOp = op; Do = d; done = dn; PC = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_issue(input int done_one_in);
        issue(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 5'($urandom),
              $urandom, 3'($urandom_range(0, 7)), $urandom,
              ($urandom_range(1, done_one_in) == 1), $urandom);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop without a clock edge.
    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        halted_m = 1'b0; instret_m = 32'd0; present_m = 1'b0; present_done_m = 1'b0;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_retire_valid", 32'(retire_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0;
        in_valid = 1'b0; MemtoReg = 1'b0; RegWr = 1'b0; Rd = 5'd0; ALUout = 32'd0;
        MemOp = 3'd0; Do = 32'd0; done = 1'b0; PC = 32'd0;
        #2;
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_instret", instret, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // LB, sign-extended top byte
        issue(1, 1, 1, 5'd5, 32'h0000_1003, 3'b000, 32'h80FF_1234, 0, 32'h100);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        // LHU / LH from the upper half
        issue(1, 1, 1, 5'd6, 32'h0000_2002, 3'b101, 32'h9ABC_0011, 0, 32'h104);
        chk("lhu_wdata", rf_wdata, 32'h0000_9ABC);
        issue(1, 1, 1, 5'd6, 32'h0000_2003, 3'b001, 32'h9ABC_0011, 0, 32'h108);
        chk("lh_wdata", rf_wdata, 32'hFFFF_9ABC);
        // Back-to-back ALU ops into x0 then x7
        issue(1, 0, 1, 5'd0, 32'h55, 3'b010, 32'h0, 0, 32'h10C);
        issue(1, 0, 1, 5'd7, 32'h55, 3'b010, 32'h0, 0, 32'h110);
        issue(0, 0, 0, 5'd0, 32'h0, 3'b000, 32'h0, 0, 32'h0);
        // hold for 3 cycles with a pending request
        hold = 1'b1;
        repeat (3) issue(1, 0, 1, 5'd9, 32'hABCD, 3'b010, 32'h0, 0, 32'h200);
        hold = 1'b0;
        issue(1, 0, 1, 5'd9, 32'hABCD, 3'b010, 32'h0, 0, 32'h200);

        // Random traffic without halts
        repeat (300) rnd_issue(1_000_000);

        // done entry followed by a continuous stream
        issue(1, 0, 1, 5'd3, 32'hD0E, 3'b010, 32'h0, 1, 32'h300);
        repeat (6) issue(1, 0, 1, 5'd4, 32'h1, 3'b010, 32'h0, 0, 32'h304);

        // Reset while an entry is presented
        issue(1, 0, 1, 5'd2, 32'h77, 3'b010, 32'h0, 0, 32'h400);
        do_reset();
        issue(1, 0, 1, 5'd2, 32'h77, 3'b010, 32'h0, 0, 32'h404);

        // Random traffic with occasional halts, recovered by reset
        for (int i = 0; i < 600; i++) begin
            rnd_issue(40);
            if (halted_m && ($urandom_range(0, 3) == 0)) do_reset();
            else if ((i % 97) == 50 && present_m) do_reset();
        end

        issue(0, 0, 0, 5'd0, 32'h0, 3'b000, 32'h0, 0, 32'h0);
        issue(0, 0, 0, 5'd0, 32'h0, 3'b000, 32'h0, 0, 32'h0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
